// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared defaults and counter sizing for the switch debouncer
package sw_debounce_pkg;

    localparam int SW_WIDTH_DEF      = 16;
    localparam int SW_SYNC_DEF       = 2;
    localparam int SW_DEB_CYCLES_DEF = 125000;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_chan.sv
// sw_debounce_chan: one switch channel - synchronizer, stability counter, accepted level, edge pulses
module sw_debounce_chan
    import sw_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = SW_SYNC_DEF,
    parameter int DEBOUNCE_CYCLES = SW_DEB_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;
    logic                   differ;

    // a new level is accepted once the synchronized input has differed for the full window
    always_comb begin
        s        = sync[SYNC_STAGES-1];
        differ   = s ^ o_sw;
        o_accept = differ && (cnt == CNT_LAST);
    end

    // synchronizer shift, stability count and registered level/edge outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync   <= '0;
            cnt    <= '0;
            o_sw   <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], i_sw};
            cnt    <= (differ && !o_accept) ? cnt + CNT_ONE : '0;
            o_sw   <= o_accept ? s : o_sw;
            o_rise <= o_accept & s;
            o_fall <= o_accept & ~s;
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit switch debouncer with edge pulses and sticky change flags; SW_DEBOUNCE_IRQ_EN adds a masked level interrupt
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH_DEF,
    parameter int SYNC_STAGES     = SW_SYNC_DEF,
    parameter int DEBOUNCE_CYCLES = SW_DEB_CYCLES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_sw,
    output logic [WIDTH-1:0] o_sw,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic [WIDTH-1:0] o_changed,
    input  logic [WIDTH-1:0] i_clr_changed
`ifdef SW_DEBOUNCE_IRQ_EN
    ,
    input  logic [WIDTH-1:0] i_irq_mask,
    output logic             o_irq
`endif
);

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] changed_next;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_chan
            sw_debounce_chan #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_chan (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_sw    (i_sw[i]),
                .o_sw    (o_sw[i]),
                .o_rise  (o_rise[i]),
                .o_fall  (o_fall[i]),
                .o_accept(accept[i])
            );
        end
    endgenerate

    // a fresh accepted edge beats a simultaneous clear
    always_comb changed_next = (o_changed & ~i_clr_changed) | accept;

    // sticky change flags
    always_ff @(posedge i_clk) begin
        if (i_rst) o_changed <= '0;
        else       o_changed <= changed_next;
    end

`ifdef SW_DEBOUNCE_IRQ_EN
    // level interrupt from the flags that will be held after this edge
    always_ff @(posedge i_clk) begin
        if (i_rst) o_irq <= 1'b0;
        else       o_irq <= |(changed_next & i_irq_mask);
    end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed table, corner sequences and randomized traffic against a window-based reference model
module tb_sw_debounce;

    localparam int W  = 16;
    localparam int DC = 8;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [W-1:0] i_sw = '0;
    logic [W-1:0] i_clr_changed = '0;
    logic [W-1:0] o_sw, o_rise, o_fall, o_changed;
`ifdef SW_DEBOUNCE_IRQ_EN
    logic [W-1:0] i_irq_mask = '0;
    logic         o_irq;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 i_clk = ~i_clk;

    sw_debounce #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DC)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_sw         (i_sw),
        .o_sw         (o_sw),
        .o_rise       (o_rise),
        .o_fall       (o_fall),
        .o_changed    (o_changed),
        .i_clr_changed(i_clr_changed)
`ifdef SW_DEBOUNCE_IRQ_EN
        ,
        .i_irq_mask   (i_irq_mask),
        .o_irq        (o_irq)
`endif
    );

    // Reference model: raw samples are seen two edges later; a bit is accepted
    // when the last DC seen samples all differ from the current level.
    logic [W-1:0] raw_q[$];
    logic [W-1:0] s_hist[$];
    logic [W-1:0] m_sw = '0, m_rise = '0, m_fall = '0, m_chg = '0;
    logic         m_irq = 1'b0;

    task automatic model_edge();
        logic [W-1:0] s, acc;
        if (i_rst) begin
            raw_q = '{W'(0), W'(0)};
            s_hist.delete();
            m_sw = '0; m_rise = '0; m_fall = '0; m_chg = '0; m_irq = 1'b0;
            return;
        end
        raw_q.push_back(i_sw);
        s = raw_q.pop_front();
        s_hist.push_back(s);
        if (s_hist.size() > DC) void'(s_hist.pop_front());
        acc = (s_hist.size() == DC) ? '1 : '0;
        foreach (s_hist[j]) acc &= s_hist[j] ^ m_sw;
        m_rise = acc & s;
        m_fall = acc & ~s;
        m_sw   = (m_sw & ~acc) | (s & acc);
        m_chg  = (m_chg & ~i_clr_changed) | acc;
`ifdef SW_DEBOUNCE_IRQ_EN
        m_irq  = |(m_chg & i_irq_mask);
`endif
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        model_edge();
        #1;
        chk("model o_sw", o_sw, m_sw);
        chk("model o_rise", o_rise, m_rise);
        chk("model o_fall", o_fall, m_fall);
        chk("model o_changed", o_changed, m_chg);
`ifdef SW_DEBOUNCE_IRQ_EN
        chk("model o_irq", W'(o_irq), W'(m_irq));
`endif
    endtask

    typedef struct {
        logic         rst;
        logic [W-1:0] sw, clr;
        int           n;
        logic [W-1:0] e_sw, e_rise, e_fall, e_chg;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // all high through reset, accepted 10 edges after release
        tbl.push_back('{1'b1, 16'hFFFF, 16'h0000,  2, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 16'hFFFF, 16'h0000,  9, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 16'hFFFF, 16'h0000,  1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF});
        tbl.push_back('{1'b0, 16'hFFFF, 16'h0000,  1, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF});
        tbl.push_back('{1'b0, 16'hFFFF, 16'hFFFF,  1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000});
        // bit3 high for one cycle short of the window
        tbl.push_back('{1'b1, 16'h0000, 16'h0000,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 16'h0008, 16'h0000,  7, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000, 12, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        // bit0 bounce then hold
        tbl.push_back('{1'b0, 16'h0001, 16'h0000,  3, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000,  3, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 16'h0001, 16'h0000,  3, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000,  3, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 16'h0001, 16'h0000,  9, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 16'h0001, 16'h0000,  1, 16'h0001, 16'h0001, 16'h0000, 16'h0001});
        tbl.push_back('{1'b0, 16'h0001, 16'h0001,  1, 16'h0001, 16'h0000, 16'h0000, 16'h0000});
        // bit5: set wins over simultaneous clear
        tbl.push_back('{1'b0, 16'h0021, 16'h0000, 10, 16'h0021, 16'h0020, 16'h0000, 16'h0020});
        tbl.push_back('{1'b0, 16'h0001, 16'h0000,  9, 16'h0021, 16'h0000, 16'h0000, 16'h0020});
        tbl.push_back('{1'b0, 16'h0001, 16'h0020,  1, 16'h0001, 16'h0000, 16'h0020, 16'h0020});
        tbl.push_back('{1'b0, 16'h0001, 16'h0020,  1, 16'h0001, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 16'h0001, 16'h0000,  1, 16'h0001, 16'h0000, 16'h0000, 16'h0000});
        // bit7 mid-count reset restarts the window
        tbl.push_back('{1'b0, 16'h0081, 16'h0000,  5, 16'h0001, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{1'b1, 16'h0081, 16'h0000,  1, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 16'h0081, 16'h0000,  9, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 16'h0081, 16'h0000,  1, 16'h0081, 16'h0081, 16'h0000, 16'h0081});

        foreach (tbl[k]) begin
            i_rst = tbl[k].rst;
            i_sw = tbl[k].sw;
            i_clr_changed = tbl[k].clr;
            repeat (tbl[k].n) step();
            chk($sformatf("tbl%0d o_sw", k), o_sw, tbl[k].e_sw);
            chk($sformatf("tbl%0d o_rise", k), o_rise, tbl[k].e_rise);
            chk($sformatf("tbl%0d o_fall", k), o_fall, tbl[k].e_fall);
            chk($sformatf("tbl%0d o_changed", k), o_changed, tbl[k].e_chg);
        end

`ifdef SW_DEBOUNCE_IRQ_EN
        // interrupt masked to bit1 only
        i_rst = 1'b1; i_sw = '0; i_clr_changed = '0; i_irq_mask = 16'h0002;
        step();
        i_rst = 1'b0; i_sw = 16'h0001;
        repeat (10) step();
        chk("irq bit0 changed", o_changed, 16'h0001);
        chk("irq bit0 masked", W'(o_irq), W'(0));
        i_sw = 16'h0003;
        repeat (10) step();
        chk("irq bit1 changed", o_changed, 16'h0003);
        chk("irq bit1 set", W'(o_irq), W'(1));
        i_clr_changed = 16'h0002;
        step();
        chk("irq clr changed", o_changed, 16'h0001);
        chk("irq clr", W'(o_irq), W'(0));
        i_clr_changed = '0;
`endif

        // randomized traffic: sparse toggles, sparse clears, rare resets
        for (int c = 0; c < 3000; c++) begin
            i_rst = ($urandom_range(0, 299) == 0);
            i_sw = i_sw ^ W'($urandom & $urandom & $urandom & $urandom);
            i_clr_changed = W'($urandom & $urandom & $urandom);
`ifdef SW_DEBOUNCE_IRQ_EN
            if ($urandom_range(0, 99) == 0) i_irq_mask = W'($urandom);
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
